uart_tx_ctrl: RTL and testbench

// - UART transmit controller: serialises one NB_DATA-bit word per request onto o_tx, sequenced by the
//   16x-oversampling tick from baudrateGenerator (o_tick_ovf -> i_tick).
// - Frame: 1 start bit, NB_DATA data bits (LSB first), optional parity bit, stop period of SB_TICK ticks.
// - Sits between the TX interface/FIFO (i_tx_start/i_data) and the serial pin.

---
 rtl/uart_tx_ctrl_if.sv | 21 ++
 rtl/uart_tx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - tick/request/data inputs and serial/status outputs of the UART transmitter
interface uart_tx_ctrl_if #(
  parameter int NB_DATA = 8
);
  logic               i_tick;
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_busy;
  logic               o_tx_done;

  modport master (
    output i_tick, i_tx_start, i_data,
    input  o_tx, o_busy, o_tx_done
  );

  modport slave (
    input  i_tick, i_tx_start, i_data,
    output o_tx, o_busy, o_tx_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller sequenced by a 16x oversampling tick
module uart_tx_ctrl #(
  parameter int NB_DATA    = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  uart_tx_ctrl_if.slave bus
);

  // Tick counter must also reach SB_TICK-1 for 1.5/2 stop-bit settings.
  localparam int   S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int   N_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [S_W-1:0]     s_q, s_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic               p_q, p_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // tx_d always carries the line level of the state being entered, so the pin moves with the state.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.i_tx_start) begin
          b_d     = bus.i_data;
          p_d     = (^bus.i_data) ^ ODD;
          s_d     = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bus.i_tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      DATA: begin
        if (bus.i_tick) begin
          if (s_q == S_W'(15)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_W'(NB_DATA - 1)) begin
              if (PARITY_EN != 0) begin
                state_d = PARITY;
                tx_d    = p_q;
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              n_d  = n_q + N_W'(1);
              tx_d = b_q[1];
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      PARITY: begin
        if (bus.i_tick) begin
          if (s_q == S_W'(15)) begin
            s_d     = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      STOP: begin
        if (bus.i_tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign bus.o_tx      = tx_q;
  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed bench: 8N1, even/odd parity and 2-stop variants driven in parallel
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] tcnt = 2'd0;
  logic       tick;
  logic       tx_start = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] tx_v, busy_v, done_v;

  int total = 0;
  int bad = 0;

  logic [11:0] smp [4];
  int          done_cyc [4];
  int          done_cnt [4];
  logic [3:0]  busy_mid;

  always #5 clk = ~clk;

  // Tick every 4 clocks, free running like the baud generator.
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign tick = (tcnt == 2'd3);

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2 (SB_TICK=32)
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int PE = (g == 1 || g == 2) ? 1 : 0;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 3) ? 32 : 16;
    uart_tx_ctrl_if #(.NB_DATA(8)) bus ();
    assign bus.i_tick     = tick;
    assign bus.i_tx_start = tx_start;
    assign bus.i_data     = data;
    assign tx_v[g]        = bus.o_tx;
    assign busy_v[g]      = bus.o_busy;
    assign done_v[g]      = bus.o_tx_done;
    uart_tx_ctrl #(.NB_DATA(8), .SB_TICK(SB), .PARITY_EN(PE), .PARITY_ODD(PO)) u_dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise the request so it is sampled on a tick edge.
  task automatic start_aligned(input logic [7:0] d);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
    check("tick_align", {31'd0, found}, 32'd1);
    data     = d;
    tx_start = 1'b1;
  endtask

  // c=1 is the negedge right after the accepting edge; bit i is sampled mid-bit at c=64*i+33.
  task automatic watch(input int max_cyc, input int inj_cyc, input logic b2b, input logic [7:0] b2b_data);
    int idx;
    for (int k = 0; k < 4; k++) begin
      smp[k]      = '0;
      done_cyc[k] = 0;
      done_cnt[k] = 0;
    end
    busy_mid = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == 1) tx_start = 1'b0;
      if (c == inj_cyc) begin
        tx_start = 1'b1;
        data     = 8'hFF;
      end
      if (c == inj_cyc + 1) tx_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (c >= 33 && ((c - 33) % 64) == 0) begin
          idx = (c - 33) / 64;
          if (idx < 12) smp[k][idx] = tx_v[k];
        end
        if (done_v[k]) begin
          done_cnt[k]++;
          if (done_cyc[k] == 0) done_cyc[k] = c;
        end
      end
      if (c == 100) busy_mid = busy_v;
      if (b2b && done_v[0]) begin
        tx_start = 1'b1;
        data     = b2b_data;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] idle_low;

    repeat (3) @(negedge clk);
    check("rst_tx", {28'd0, tx_v}, 32'hF);
    check("rst_busy", {28'd0, busy_v}, 32'h0);
    check("rst_done", {28'd0, done_v}, 32'h0);
    rst_n = 1'b1;

    idle_low = '0;
    repeat (100) begin
      @(negedge clk);
      idle_low = idle_low | ~tx_v | busy_v;
    end
    check("idle_line", {28'd0, idle_low}, 32'h0);

    // A5 on all variants, with a request injected mid-frame that must be ignored.
    start_aligned(8'hA5);
    watch(800, 200, 1'b0, 8'h00);
    check("a5_8n1_bits", {20'd0, smp[0][9:0]}, {22'd0, 1'b1, 8'hA5, 1'b0});
    check("a5_even_bits", {21'd0, smp[1][10:0]}, {21'd0, 1'b1, 1'b0, 8'hA5, 1'b0});
    check("a5_odd_bits", {21'd0, smp[2][10:0]}, {21'd0, 1'b1, 1'b1, 8'hA5, 1'b0});
    check("a5_sb32_bits", {21'd0, smp[3][10:0]}, {21'd0, 1'b1, 1'b1, 8'hA5, 1'b0});
    check("a5_8n1_done_cyc", done_cyc[0], 641);
    check("a5_even_done_cyc", done_cyc[1], 705);
    check("a5_odd_done_cyc", done_cyc[2], 705);
    check("a5_sb32_done_cyc", done_cyc[3], 705);
    check("a5_8n1_done_cnt", done_cnt[0], 1);
    check("a5_sb32_done_cnt", done_cnt[3], 1);
    check("a5_busy_mid", {28'd0, busy_mid}, 32'hF);
    check("a5_busy_end", {28'd0, busy_v}, 32'h0);

    start_aligned(8'h07);
    watch(800, -1, 1'b0, 8'h00);
    check("07_even_bits", {21'd0, smp[1][10:0]}, {21'd0, 1'b1, 1'b1, 8'h07, 1'b0});
    check("07_odd_bits", {21'd0, smp[2][10:0]}, {21'd0, 1'b1, 1'b0, 8'h07, 1'b0});
    check("07_even_done_cyc", done_cyc[1], 705);

    // Back-to-back: second request raised in the o_tx_done cycle.
    start_aligned(8'hA5);
    watch(800, 200, 1'b1, 8'h3C);
    check("b2b_f1_bits", {20'd0, smp[0][9:0]}, {22'd0, 1'b1, 8'hA5, 1'b0});
    check("b2b_f1_done_cyc", done_cyc[0], 641);
    watch(800, -1, 1'b0, 8'h00);
    check("b2b_f2_bits", {20'd0, smp[0][9:0]}, {22'd0, 1'b1, 8'h3C, 1'b0});
    check("b2b_f2_done_cyc", done_cyc[0], 640);
    check("b2b_f2_done_cnt", done_cnt[0], 1);
    check("b2b_busy_end", {28'd0, busy_v}, 32'h0);

    // Reset while data bit 4 (a 0 for A5) is on the line.
    start_aligned(8'hA5);
    watch(352, -1, 1'b0, 8'h00);
    @(negedge clk);
    check("pre_rst_tx", {31'd0, tx_v[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {28'd0, tx_v}, 32'hF);
    check("mid_rst_busy", {28'd0, busy_v}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    watch(800, -1, 1'b0, 8'h00);
    check("post_rst_no_done0", done_cnt[0], 0);
    check("post_rst_no_done3", done_cnt[3], 0);
    start_aligned(8'h3C);
    watch(800, -1, 1'b0, 8'h00);
    check("post_rst_bits", {20'd0, smp[0][9:0]}, {22'd0, 1'b1, 8'h3C, 1'b0});
    check("post_rst_even_bits", {21'd0, smp[1][10:0]}, {21'd0, 1'b1, 1'b0, 8'h3C, 1'b0});
    check("post_rst_done_cyc", done_cyc[0], 641);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
